// File: rtl/bsg_mem_1rw_sync_arb.sv
// Round-robin arbiter sharing one 1rw sync SRAM among num_req_p requesters.
// Ports: req_* (valid/write/addr/data, yumi grant), resp_* (valid/data/ready),
//   mem_* (strobe/we/addr/wdata out, rdata in one cycle after a read).
module bsg_mem_1rw_sync_arb #(
  parameter int width_p   = 8,
  parameter int els_p     = 16,
  parameter int num_req_p = 2,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_req_p-1:0]               req_v_i,
  input  logic [num_req_p-1:0]               req_w_i,
  input  logic [num_req_p*addr_width_lp-1:0] req_addr_i,
  input  logic [num_req_p*width_p-1:0]       req_data_i,
  output logic [num_req_p-1:0]               req_yumi_o,
  output logic [num_req_p-1:0]               resp_v_o,
  output logic [num_req_p*width_p-1:0]       resp_data_o,
  input  logic [num_req_p-1:0]               resp_ready_i,
  output logic                               mem_v_o,
  output logic                               mem_w_o,
  output logic [addr_width_lp-1:0]           mem_addr_o,
  output logic [width_p-1:0]                 mem_data_o,
  input  logic [width_p-1:0]                 mem_data_i
);

  // Pointer is at least 1 bit wide so num_req_p == 1 elaborates cleanly.
  localparam int lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  typedef enum logic [1:0] {
    E_EMPTY    = 2'd0,
    E_INFLIGHT = 2'd1,
    E_FULL     = 2'd2
  } resp_state_e;

  resp_state_e st_q [num_req_p];
  resp_state_e st_d [num_req_p];

  logic [num_req_p-1:0][width_p-1:0] data_q;
  logic [num_req_p-1:0][width_p-1:0] data_d;

  logic [lg_req_lp-1:0] last_q;
  logic [lg_req_lp-1:0] last_d;

  logic [num_req_p-1:0] elig;
  logic [num_req_p-1:0] grant;
  logic                 found;
  int                   idx;

  // A read may issue only if its buffer will be free next cycle.
  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      elig[i] = req_v_i[i]
              & (req_w_i[i] | (st_q[i] == E_EMPTY) | resp_ready_i[i]);
    end
  end

  always_comb begin
    grant  = '0;
    found  = 1'b0;
    idx    = 0;
    last_d = last_q;
    for (int k = 1; k <= num_req_p; k++) begin
      idx = (int'(last_q) + k) % num_req_p;
      if (!found && !reset_i && elig[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        last_d     = lg_req_lp'(idx);
      end
    end
  end

  assign req_yumi_o = grant;
  assign mem_v_o    = |grant;

  always_comb begin
    mem_w_o    = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant[i]) begin
        mem_w_o    = req_w_i[i];
        mem_addr_o = req_addr_i[i*addr_width_lp +: addr_width_lp];
        mem_data_o = req_data_i[i*width_p +: width_p];
      end
    end
  end

  always_comb begin
    logic g;
    logic r;
    g = 1'b0;
    r = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      st_d[i]   = st_q[i];
      data_d[i] = data_q[i];
      g = grant[i] & ~req_w_i[i];
      r = resp_ready_i[i];
      unique case (st_q[i])
        E_EMPTY: begin
          if (g) st_d[i] = E_INFLIGHT;
        end
        E_INFLIGHT: begin
          if (r) begin
            st_d[i] = g ? E_INFLIGHT : E_EMPTY;
          end else begin
            st_d[i]   = E_FULL;
            data_d[i] = mem_data_i;
          end
        end
        E_FULL: begin
          if (r) st_d[i] = g ? E_INFLIGHT : E_EMPTY;
        end
        default: st_d[i] = E_EMPTY;
      endcase
    end
  end

  always_comb begin
    resp_v_o    = '0;
    resp_data_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      resp_v_o[i] = ~reset_i & (st_q[i] != E_EMPTY);
      unique case (st_q[i])
        E_INFLIGHT: resp_data_o[i*width_p +: width_p] = mem_data_i;
        E_FULL:     resp_data_o[i*width_p +: width_p] = data_q[i];
        default:    resp_data_o[i*width_p +: width_p] = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_req_p; i++) st_q[i] <= E_EMPTY;
      last_q <= lg_req_lp'(num_req_p - 1);
    end else begin
      for (int i = 0; i < num_req_p; i++) st_q[i] <= st_d[i];
      last_q <= last_d;
    end
  end

  // Holding registers need no reset; their state bit guards them.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

endmodule

// File: tb/tb_bsg_mem_1rw_sync_arb.sv
// Bench for bsg_mem_1rw_sync_arb: directed steps then random traffic,
// checked each cycle against a slot/queue-level reference model.
module tb_bsg_mem_1rw_sync_arb;

  localparam int W  = 8;
  localparam int E  = 16;
  localparam int N  = 2;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [N-1:0]    req_v_i, req_w_i, req_yumi_o;
  logic [N*AW-1:0] req_addr_i;
  logic [N*W-1:0]  req_data_i;
  logic [N-1:0]    resp_v_o, resp_ready_i;
  logic [N*W-1:0]  resp_data_o;
  logic            mem_v_o, mem_w_o;
  logic [AW-1:0]   mem_addr_o;
  logic [W-1:0]    mem_data_o;
  logic [W-1:0]    mem_data_i;

  bsg_mem_1rw_sync_arb #(.width_p(W), .els_p(E), .num_req_p(N)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_w_i(req_w_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_yumi_o(req_yumi_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
    .resp_ready_i(resp_ready_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  // Environment SRAM
  logic [W-1:0] sram [E];
  always @(posedge clk) begin
    if (mem_v_o && mem_w_o) sram[mem_addr_o] <= mem_data_o;
    if (mem_v_o && !mem_w_o) mem_data_i <= sram[mem_addr_o];
  end

  // Reference model: memory image, one response slot per requester, pointer
  logic [W-1:0] ref_mem [E];
  bit           slot_v [N];
  logic [W-1:0] slot_d [N];
  int           last;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input logic [1:0] v, input logic [1:0] w,
                     input logic [1:0] rdy,
                     input logic [3:0] a0, input logic [3:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input bit rst);
    logic [3:0] a [N];
    logic [7:0] d [N];
    int eg;
    int j;
    a[0] = a0; a[1] = a1;
    d[0] = d0; d[1] = d1;
    reset_i      = rst;
    req_v_i      = v;
    req_w_i      = w;
    resp_ready_i = rdy;
    req_addr_i   = {a1, a0};
    req_data_i   = {d1, d0};
    @(negedge clk);
    eg = -1;
    if (!rst) begin
      for (int k = 1; k <= N; k++) begin
        j = (last + k) % N;
        if (eg < 0 && v[j] && (w[j] || !slot_v[j] || rdy[j])) eg = j;
      end
    end
    chk("yumi", 32'(req_yumi_o), (eg >= 0) ? (32'd1 << eg) : 32'd0);
    chk("mem_v", 32'(mem_v_o), 32'(eg >= 0));
    chk("mem_w", 32'(mem_w_o), (eg >= 0) ? 32'(w[eg]) : 32'd0);
    chk("mem_addr", 32'(mem_addr_o), (eg >= 0) ? 32'(a[eg]) : 32'd0);
    chk("mem_data", 32'(mem_data_o), (eg >= 0) ? 32'(d[eg]) : 32'd0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("resp_v%0d", i), 32'(resp_v_o[i]),
          32'(!rst && slot_v[i]));
      if (!rst && slot_v[i])
        chk($sformatf("resp_data%0d", i),
            32'(resp_data_o[i*W +: W]), 32'(slot_d[i]));
    end
    if (rst) begin
      for (int i = 0; i < N; i++) slot_v[i] = 0;
      last = N - 1;
    end else begin
      for (int i = 0; i < N; i++)
        if (slot_v[i] && rdy[i]) slot_v[i] = 0;
      if (eg >= 0) begin
        if (w[eg]) ref_mem[a[eg]] = d[eg];
        else begin
          slot_v[eg] = 1;
          slot_d[eg] = ref_mem[a[eg]];
        end
        last = eg;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < E; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      slot_v[i] = 0;
      slot_d[i] = '0;
    end
    last = N - 1;
    mem_data_i = '0;
    reset_i = 1'b1;
    req_v_i = '0; req_w_i = '0; resp_ready_i = '0;
    req_addr_i = '0; req_data_i = '0;
    @(posedge clk); #1;

    // Reset, with a request asserted to show yumi is held low
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    cyc(2'b01, 2'b00, 2'b11, 1, 0, 0, 0, 1);

    // Single write then read of addr 3
    cyc(2'b01, 2'b01, 2'b11, 3, 0, 8'hA5, 0, 0);
    cyc(2'b01, 2'b00, 2'b11, 3, 0, 0, 0, 0);
    cyc(2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0);

    // Fairness from a fresh pointer
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++)
      cyc(2'b11, 2'b00, 2'b11, 3, 4'(i), 0, 0, 0);
    cyc(2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0);

    // Backpressure, then ready-and-reissue
    cyc(2'b01, 2'b01, 2'b11, 5, 0, 8'h11, 0, 0);
    cyc(2'b01, 2'b00, 2'b00, 5, 0, 0, 0, 0);
    cyc(2'b11, 2'b10, 2'b00, 5, 5, 0, 8'h22, 0);
    for (int i = 0; i < 3; i++)
      cyc(2'b01, 2'b00, 2'b00, 5, 0, 0, 0, 0);
    cyc(2'b01, 2'b00, 2'b01, 5, 0, 0, 0, 0);
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    cyc(2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0);

    // Mid-operation reset right after a read grant
    cyc(2'b01, 2'b00, 2'b11, 3, 0, 0, 0, 0);
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    cyc(2'b11, 2'b00, 2'b11, 5, 3, 0, 0, 0);
    cyc(2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0);

    // Idle: nothing driven to memory, pointer untouched
    for (int i = 0; i < 3; i++)
      cyc(2'b00, 2'b11, 2'b11, 4'hF, 4'hF, 8'hFF, 8'hFF, 0);
    cyc(2'b11, 2'b00, 2'b11, 1, 2, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      cyc(2'($urandom), 2'($urandom),
          2'($urandom | $urandom),
          4'($urandom), 4'($urandom),
          8'($urandom), 8'($urandom),
          ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
